// File: rtl/thermal_pkg.sv
// Shared definitions for the thermal supervisor: FSM encodings and default thresholds.
package thermal_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_NORMAL   = 2'd0,
    ST_COOLING  = 2'd1,
    ST_SHUTDOWN = 2'd2,
    ST_UNUSED   = 2'd3
  } state_e;

  localparam int DEF_COOL_ON    = 45;
  localparam int DEF_COOL_OFF   = 40;
  localparam int DEF_CRIT_LIMIT = 60;
  localparam int DEF_PERSIST    = 4;

endpackage

// File: rtl/thermal_persist_cnt.sv
// Saturating consecutive-event counter. Counts samples where hit holds, restarts
// on a sample where it fails, holds between samples. reached is combinational on
// the counter's next value so the caller can act on the same edge that registers
// the PERSIST-th qualifying sample.
module thermal_persist_cnt #(
  parameter int PERSIST = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_valid,
  input  logic hit,
  input  logic clr,
  output logic reached
);

  localparam int CNT_W = (PERSIST < 1) ? 1 : $clog2(PERSIST + 1);
  localparam logic [CNT_W-1:0] L_MAX = CNT_W'(PERSIST);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next count: clear wins, then sample update, otherwise hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr) begin
      w_cnt_nxt = '0;
    end else if (sample_valid) begin
      if (!hit) begin
        w_cnt_nxt = '0;
      end else if (r_cnt != L_MAX) begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign reached = (w_cnt_nxt == L_MAX);

endmodule

// File: rtl/thermal_supervisor.sv
// Multi-channel thermal supervisor: persistence-filtered cooling with hysteresis,
// latched critical shutdown with explicit clear, and a hottest-channel report.
module thermal_supervisor
  import thermal_pkg::*;
#(
  parameter int NUM_SENSORS = 2,
  parameter int TEMP_W      = 8,
  parameter int COOL_ON     = DEF_COOL_ON,
  parameter int COOL_OFF    = DEF_COOL_OFF,
  parameter int CRIT_LIMIT  = DEF_CRIT_LIMIT,
  parameter int PERSIST     = DEF_PERSIST,
  parameter int COOL_MODE   = 0,
  localparam int IDX_W      = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_valid,
  input  logic [NUM_SENSORS*TEMP_W-1:0] temp_bus,
  input  logic                          crit_clear,
  output logic                          peltier_enable,
  output logic                          critical_shutdown,
  output logic [STATE_W-1:0]            state,
  output logic [TEMP_W-1:0]             hottest_temp,
  output logic [IDX_W-1:0]              hottest_idx
);

  // Bad configurations stop elaboration.
  if (NUM_SENSORS < 1) begin : g_err_num_sensors
    $error("thermal_supervisor: NUM_SENSORS must be >= 1");
  end
  if (PERSIST < 1) begin : g_err_persist
    $error("thermal_supervisor: PERSIST must be >= 1");
  end
  if (!(COOL_OFF < COOL_ON)) begin : g_err_cool_order
    $error("thermal_supervisor: COOL_OFF must be below COOL_ON");
  end
  if (!(COOL_ON < CRIT_LIMIT)) begin : g_err_crit_order
    $error("thermal_supervisor: COOL_ON must be below CRIT_LIMIT");
  end

  localparam logic [TEMP_W-1:0] L_COOL_ON  = TEMP_W'(COOL_ON);
  localparam logic [TEMP_W-1:0] L_COOL_OFF = TEMP_W'(COOL_OFF);
  localparam logic [TEMP_W-1:0] L_CRIT     = TEMP_W'(CRIT_LIMIT);

  logic [TEMP_W-1:0]             w_temps [NUM_SENSORS];
  logic [NUM_SENSORS*TEMP_W-1:0] r_last;
  logic [TEMP_W-1:0]             r_hot;
  logic [IDX_W-1:0]              r_idx;
  logic [TEMP_W-1:0]             w_hot;
  logic [IDX_W-1:0]              w_idx;

  logic w_on_any, w_on_all, w_off_all, w_crit_any, w_last_off;
  logic w_on_hit, w_leave_sd;
  logic w_on_reached, w_off_reached, w_crit_reached;

  state_e r_state, w_state_nxt;
  logic   r_pelt, r_crit, w_pelt_nxt, w_crit_nxt;

  // Split the bus into per-channel values.
  always_comb begin
    for (int i = 0; i < NUM_SENSORS; i++) begin
      w_temps[i] = temp_bus[i*TEMP_W +: TEMP_W];
    end
  end

  // Hottest channel of the incoming sample; strict compare keeps the lowest index on ties.
  always_comb begin
    w_hot = w_temps[0];
    w_idx = '0;
    for (int i = 1; i < NUM_SENSORS; i++) begin
      if (w_temps[i] > w_hot) begin
        w_hot = w_temps[i];
        w_idx = IDX_W'(i);
      end
    end
  end

  // Threshold conditions on the incoming sample, plus off condition of the stored sample.
  always_comb begin
    w_on_any   = 1'b0;
    w_on_all   = 1'b1;
    w_off_all  = 1'b1;
    w_crit_any = 1'b0;
    w_last_off = 1'b1;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      if (w_temps[i] > L_COOL_ON) w_on_any = 1'b1;
      else                        w_on_all = 1'b0;
      if (!(w_temps[i] < L_COOL_OFF)) w_off_all = 1'b0;
      if (w_temps[i] > L_CRIT) w_crit_any = 1'b1;
      if (!(r_last[i*TEMP_W +: TEMP_W] < L_COOL_OFF)) w_last_off = 1'b0;
    end
  end

  assign w_on_hit = (COOL_MODE != 0) ? w_on_any : w_on_all;

  // Leaving shutdown depends only on the clear request and the previously captured
  // sample, never on the counters, so it can safely clear them in the same cycle.
  assign w_leave_sd = (r_state == ST_SHUTDOWN) && crit_clear && w_last_off;

  thermal_persist_cnt #(.PERSIST(PERSIST)) u_on_cnt (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .hit(w_on_hit), .clr(w_leave_sd), .reached(w_on_reached)
  );

  thermal_persist_cnt #(.PERSIST(PERSIST)) u_off_cnt (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .hit(w_off_all), .clr(w_leave_sd), .reached(w_off_reached)
  );

  thermal_persist_cnt #(.PERSIST(PERSIST)) u_crit_cnt (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .hit(w_crit_any), .clr(w_leave_sd), .reached(w_crit_reached)
  );

  // Sample capture: last raw sample and hottest-channel report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= '0;
      r_hot  <= '0;
      r_idx  <= '0;
    end else if (sample_valid) begin
      r_last <= temp_bus;
      r_hot  <= w_hot;
      r_idx  <= w_idx;
    end
  end

  // FSM state register with registered output decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_NORMAL;
      r_pelt  <= 1'b0;
      r_crit  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pelt  <= w_pelt_nxt;
      r_crit  <= w_crit_nxt;
    end
  end

  // FSM next state; critical escalation outranks every other transition.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_NORMAL: begin
        if (w_crit_reached)     w_state_nxt = ST_SHUTDOWN;
        else if (w_on_reached)  w_state_nxt = ST_COOLING;
      end
      ST_COOLING: begin
        if (w_crit_reached)     w_state_nxt = ST_SHUTDOWN;
        else if (w_off_reached) w_state_nxt = ST_NORMAL;
      end
      ST_SHUTDOWN: begin
        if (w_leave_sd)         w_state_nxt = ST_NORMAL;
      end
      default: begin
        if (w_crit_reached)     w_state_nxt = ST_SHUTDOWN;
        else                    w_state_nxt = ST_NORMAL;
      end
    endcase
  end

  // Output decode of the next state, registered alongside it.
  always_comb begin
    w_pelt_nxt = (w_state_nxt == ST_COOLING) || (w_state_nxt == ST_SHUTDOWN);
    w_crit_nxt = (w_state_nxt == ST_SHUTDOWN);
  end

  assign state             = r_state;
  assign peltier_enable    = r_pelt;
  assign critical_shutdown = r_crit;
  assign hottest_temp      = r_hot;
  assign hottest_idx       = r_idx;

endmodule
